fp_mul_seq: RTL and testbench

Parametrised, sequential sign/exponent/fraction floating-point multiplier with valid/ready handshakes, selectable rounding, and overflow/underflow flags. It is the next generation of the team's combinational 8-bit (1/3/4, bias 3) multiplier. It generalises exponent and fraction widths. It computes the significand product with an iterative shift-add engine, trading latency for area. It sits between operand producers and downstream accumulators in the arithmetic datapath.

---
 rtl/fp_mul_pkg.sv | 24 ++
 rtl/fp_mul_seq_if.sv | 30 +++
 rtl/sig_mul_seq.sv | 54 +++++
 rtl/fp_mul_seq.sv | 138 +++++++++++++
 tb/tb_fp_mul_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types for the sequential sign/exponent/fraction multiplier:
// FSM states, result classes and the default exponent bias.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_DONE
  } state_e;

  // Result classes, listed in priority order (zero beats underflow beats overflow).
  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_UNF,
    CLS_OVF
  } cls_e;

  function automatic int default_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq; the producer/consumer side
// uses the master modport, the multiplier uses the slave modport.
interface fp_mul_seq_if #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rnd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         ovf;
  logic         unf;

  modport master (
    output in_valid, a, b, rnd, out_ready,
    input  in_ready, out_valid, y, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, rnd, out_ready,
    output in_ready, out_valid, y, ovf, unf
  );

endinterface

// File: rtl/sig_mul_seq.sv
// Iterative shift-add significand multiplier: one multiplier bit per cycle,
// LSB first; product is valid once done_o has been seen.
module sig_mul_seq #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N-1:0]   mcand_i,
  input  logic [N-1:0]   mplier_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);

  localparam int              CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     mcand_q;
  logic [2*N-1:0]   acc_q;
  logic [N:0]       sum;

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  // Upper half accumulates the partial sum; lower half still holds unused multiplier bits.
  assign sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  // NOTE: datapath flops have no reset; busy_q qualifies them and start_i always reloads them.
  always_ff @(posedge clk) begin
    if (start_i) begin
      mcand_q <= mcand_i;
      acc_q   <= {{N{1'b0}}, mplier_i};
    end else if (busy_q) begin
      acc_q <= {sum, acc_q[N-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign prod_o = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: handshake, exponent path, normalisation,
// rounding and saturation around the iterative significand multiplier.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4,
  parameter int BIAS   = default_bias(EXP_W)
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_mul_seq_if.slave bus
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * FRAC_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_MIN = EW2'(1);

  state_e state_q, state_d;

  logic                  idle;
  logic                  accept;
  logic                  mul_done;
  logic [PW-1:0]         prod;
  logic [EXP_W-1:0]      exp_a, exp_b;
  logic signed [EW2-1:0] exp_sum;

  logic                  sign_q, zero_q, rnd_q;
  logic signed [EW2-1:0] exp_q;

  logic [PW-2:0]         norm;
  logic [FRAC_W-1:0]     frac_keep;
  logic                  guard, sticky, rnd_up, carry;
  logic [FRAC_W:0]       frac_rnd;
  logic signed [EW2-1:0] exp_inc, exp_fin;

  cls_e                  cls;
  logic [W-1:0]          y_d, y_q;
  logic                  ovf_d, ovf_q, unf_d, unf_q;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && bus.in_valid;

  assign exp_a   = bus.a[W-2 -: EXP_W];
  assign exp_b   = bus.b[W-2 -: EXP_W];
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

  sig_mul_seq #(.N(FRAC_W + 1)) u_sig_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept),
    .mcand_i  ({1'b1, bus.a[FRAC_W-1:0]}),
    .mplier_i ({1'b1, bus.b[FRAC_W-1:0]}),
    .done_o   (mul_done),
    .prod_o   (prod)
  );

  // Operand-derived fields are only consumed in NORM, always after a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q <= bus.a[W-1] ^ bus.b[W-1];
      zero_q <= (exp_a == '0) || (exp_b == '0);
      rnd_q  <= bus.rnd;
      exp_q  <= exp_sum;
    end
  end

  // Left-align so the hidden one sits just above norm; the product MSB picks the shift.
  assign norm      = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
  assign frac_keep = norm[PW-2 -: FRAC_W];
  assign guard     = norm[PW-2-FRAC_W];
  assign sticky    = |norm[PW-3-FRAC_W:0];
  assign rnd_up    = rnd_q && guard && (sticky || frac_keep[0]);
  assign frac_rnd  = {1'b0, frac_keep} + (FRAC_W + 1)'(rnd_up);
  assign carry     = frac_rnd[FRAC_W];
  assign exp_inc   = EW2'(prod[PW-1]) + EW2'(carry);
  assign exp_fin   = exp_q + exp_inc;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cls     = CLS_NORMAL;
    y_d     = {sign_q, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    unique case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_MUL;
      S_MUL:  if (mul_done) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (zero_q)                 cls = CLS_ZERO;
    else if (exp_fin < EXP_MIN) cls = CLS_UNF;
    else if (exp_fin > EXP_MAX) cls = CLS_OVF;

    case (cls)
      CLS_ZERO: y_d = '0;
      CLS_UNF: begin
        y_d   = '0;
        unf_d = 1'b1;
      end
      CLS_OVF: begin
        y_d   = {sign_q, {(W-1){1'b1}}};
        ovf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_NORM) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  assign bus.in_ready  = idle;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed and random operations on the
// 1/3/4 and 1/5/10 configurations against an integer-arithmetic reference.
module tb_fp_mul_seq;

  typedef struct packed {
    logic [15:0] y;
    logic        ovf;
    logic        unf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;   // 0 = 8-bit DUT, 1 = 16-bit DUT

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mul_seq_if #(.EXP_W(3), .FRAC_W(4))  if8 ();
  fp_mul_seq_if #(.EXP_W(5), .FRAC_W(10)) if16 ();

  fp_mul_seq #(.EXP_W(3), .FRAC_W(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  fp_mul_seq #(.EXP_W(5), .FRAC_W(10)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  wire        cur_in_ready  = sel ? if16.in_ready  : if8.in_ready;
  wire        cur_out_valid = sel ? if16.out_valid : if8.out_valid;
  wire [15:0] cur_y         = sel ? if16.y         : {8'h00, if8.y};
  wire        cur_ovf       = sel ? if16.ovf       : if8.ovf;
  wire        cur_unf       = sel ? if16.unf       : if8.unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Real-valued product of {1.frac} significands, rounded on the integer remainder.
  function automatic res_t ref_mul(input logic [15:0] a, input logic [15:0] b,
                                   input logic r, input int ew, input int fw);
    int     bias, emax, ea, eb, e, sh, sgn;
    longint ma, mb, p, m, rem, half;
    res_t   res;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    ea   = (int'(a) >> fw) & emax;
    eb   = (int'(b) >> fw) & emax;
    sgn  = ((int'(a) >> (ew + fw)) ^ (int'(b) >> (ew + fw))) & 1;
    ma   = longint'(int'(a) & ((1 << fw) - 1)) + (longint'(1) << fw);
    mb   = longint'(int'(b) & ((1 << fw) - 1)) + (longint'(1) << fw);
    p    = ma * mb;
    e    = ea + eb - bias;
    sh   = fw;
    if (p >= (longint'(1) << (2 * fw + 1))) begin
      sh = fw + 1;
      e++;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = longint'(1) << (sh - 1);
    if (r && (rem > half || (rem == half && m[0]))) m++;
    if (m == (longint'(1) << (fw + 1))) begin
      m = m >> 1;
      e++;
    end
    res = '0;
    if (ea != 0 && eb != 0) begin
      if (e < 1) res.unf = 1'b1;
      else if (e > emax) begin
        res.ovf = 1'b1;
        res.y   = 16'((sgn << (ew + fw)) | ((1 << (ew + fw)) - 1));
      end else begin
        res.y = 16'((sgn << (ew + fw)) | (e << fw) | int'(m - (longint'(1) << fw)));
      end
    end
    return res;
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic r);
    if (sel) begin
      if16.in_valid = v; if16.a = a; if16.b = b; if16.rnd = r;
    end else begin
      if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.rnd = r;
    end
  endtask

  task automatic set_out_ready(input logic v);
    if8.out_ready  = v;
    if16.out_ready = v;
  endtask

  // One full transaction; hold > 0 keeps out_ready low that many cycles in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic r,
                        input res_t exp, input int hold, input string tag);
    int n;
    int fw;
    fw = sel ? 10 : 4;
    set_out_ready(hold == 0);
    n = 0;
    while (!cur_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":in_ready"}, cur_in_ready, 1);
    drive(1'b1, a, b, r);
    @(posedge clk); #1;
    // Scramble operands and rounding mode after capture; the result must not move.
    drive(1'b0, 16'($urandom), 16'($urandom), ~r);
    n = 1;
    while (!cur_out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":latency"}, n, fw + 3);
    check({tag, ":y"}, cur_y, exp.y);
    check({tag, ":ovf"}, cur_ovf, exp.ovf);
    check({tag, ":unf"}, cur_unf, exp.unf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_y"}, cur_y, exp.y);
      check({tag, ":hold_hs"}, {cur_in_ready, cur_out_valid}, 2'b01);
    end
    set_out_ready(1'b1);
    @(posedge clk); #1;
    check({tag, ":back_idle"}, {cur_in_ready, cur_out_valid}, 2'b10);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic r,
                     input logic [7:0] y, input logic ovf, input logic unf, input string tag);
    res_t exp;
    exp = '{y: {8'h00, y}, ovf: ovf, unf: unf};
    run_op({8'h00, a}, {8'h00, b}, r, exp, 0, tag);
  endtask

  task automatic op_model(input logic [15:0] a, input logic [15:0] b, input logic r,
                          input string tag);
    if (sel) run_op(a, b, r, ref_mul(a, b, r, 5, 10), 0, tag);
    else     run_op(a, b, r, ref_mul(a, b, r, 3, 4), 0, tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":in_ready"}, cur_in_ready, 1);
    check({tag, ":out_valid"}, cur_out_valid, 0);
    check({tag, ":y"}, cur_y, 0);
    check({tag, ":flags"}, {cur_ovf, cur_unf}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 1'b0;
    set_out_ready(1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    sel = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    sel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst8");
    sel = 1'b1;
    check_reset_values("rst16");
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed set, 1/3/4 format, bias 3.
    op8(8'h30, 8'h30, 1'b0, 8'h30, 1'b0, 1'b0, "one_x_one");
    op8(8'h38, 8'h38, 1'b0, 8'h42, 1'b0, 1'b0, "norm_high");
    op8(8'h33, 8'h33, 1'b0, 8'h36, 1'b0, 1'b0, "trunc");
    op8(8'h33, 8'h33, 1'b1, 8'h37, 1'b0, 1'b0, "rne_up");
    op8(8'h32, 8'h34, 1'b1, 8'h36, 1'b0, 1'b0, "rne_tie_even");
    op8(8'h70, 8'h70, 1'b0, 8'h7F, 1'b1, 1'b0, "ovf_pos");
    op8(8'hF0, 8'h70, 1'b0, 8'hFF, 1'b1, 1'b0, "ovf_neg");
    op8(8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, "unf");
    op8(8'h00, 8'h45, 1'b0, 8'h00, 1'b0, 1'b0, "zero");

    // Backpressure: DONE held ten cycles.
    run_op(16'h38, 16'h38, 1'b0, '{y: 16'h42, ovf: 1'b0, unf: 1'b0}, 10, "backpressure");

    // Throughput with in_valid and out_ready both held high.
    set_out_ready(1'b1);
    drive(1'b1, 16'h38, 16'h38, 1'b0);
    n = 0;
    while (!cur_out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("tp_first_y", cur_y, 16'h42);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (cur_out_valid && n < 100);
    while (!cur_out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    check("tp_period", n, 8);
    check("tp_second_y", cur_y, 16'h42);
    @(posedge clk); #1;

    // Reset asserted while the significand multiply is in progress.
    drive(1'b1, 16'h33, 16'h33, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cur_out_valid) n++;
    end
    check("mid_rst_no_result", n, 0);
    op8(8'h38, 8'h38, 1'b0, 8'h42, 1'b0, 1'b0, "post_rst");

    // Random operations, 8-bit format.
    for (int i = 0; i < 40; i++) begin
      op_model(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom), $sformatf("rnd8_%0d", i));
    end

    // Same directed shapes plus random operations in the 1/5/10 format, bias 15.
    sel = 1'b1;
    op_model(16'h3C00, 16'h3C00, 1'b0, "w16_one");
    op_model(16'h3E00, 16'h3E00, 1'b0, "w16_norm_high");
    op_model(16'h3CCC, 16'h3CCC, 1'b0, "w16_trunc");
    op_model(16'h3CCC, 16'h3CCC, 1'b1, "w16_rne");
    op_model(16'h7800, 16'h7800, 1'b0, "w16_ovf");
    op_model(16'hF800, 16'h7800, 1'b0, "w16_ovf_neg");
    op_model(16'h0400, 16'h0400, 1'b0, "w16_unf");
    op_model(16'h0000, 16'h4500, 1'b0, "w16_zero");
    for (int i = 0; i < 20; i++) begin
      op_model(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd16_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
